// File: rtl/av_packet_demux.sv
// av_packet_demux: splits the Ethernet receive byte stream into video/audio bitstream buffer writes,
// parsing a 3-byte header (stream ID, 16-bit big-endian length) and counting bytes, drops and framing errors.
module av_packet_demux #(
    parameter logic [7:0] VIDEO_ID = 8'hE0,
    parameter logic [7:0] AUDIO_ID = 8'hC0,
    parameter int         CNT_W    = 24
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             Flush_I,
    input  logic [7:0]       Rx_Data_I,
    input  logic             Rx_Valid_I,
    input  logic             Rx_SOP_I,
    input  logic             Rx_EOP_I,
    output logic             Rx_Ready_O,
    input  logic             Video_Buffer_Full_I,
    output logic             Video_Buffer_Write_O,
    output logic [7:0]       Video_Data_O,
    input  logic             Audio_Buffer_Full_I,
    output logic             Audio_Buffer_Write_O,
    output logic [7:0]       Audio_Data_O,
    output logic [CNT_W-1:0] Video_Byte_Count_O,
    output logic [CNT_W-1:0] Audio_Byte_Count_O,
    output logic [CNT_W-1:0] Drop_Count_O,
    output logic [CNT_W-1:0] Error_Count_O,
    output logic             Error_O
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LEN_HI   = 3'd1;
    localparam logic [2:0] S_LEN_LO   = 3'd2;
    localparam logic [2:0] S_PAYLOAD  = 3'd3;
    localparam logic [2:0] S_WAIT_EOP = 3'd4;

    localparam logic [1:0] T_NONE = 2'd0;
    localparam logic [1:0] T_VID  = 2'd1;
    localparam logic [1:0] T_AUD  = 2'd2;

    logic [2:0]       state_q, state_d;
    logic [1:0]       tgt_q, tgt_d;
    logic [7:0]       len_hi_q, len_hi_d;
    logic [15:0]      len_q, len_d;
    logic             rdy_q;
    logic             vid_wr_q, vid_wr_d;
    logic [7:0]       vid_data_q, vid_data_d;
    logic             aud_wr_q, aud_wr_d;
    logic [7:0]       aud_data_q, aud_data_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] vid_cnt_q, vid_cnt_d;
    logic [CNT_W-1:0] aud_cnt_q, aud_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             accept;
    logic             drop_hit;
    logic [15:0]      len_dec;
    logic [15:0]      len_new;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return c + CNT_W'(en & ~&c);
    endfunction

    // rdy_q keeps ready low through reset and for the first cycle after it
    assign Rx_Ready_O = rdy_q & ~(state_q == S_PAYLOAD &
                                  ((tgt_q == T_VID & Video_Buffer_Full_I) |
                                   (tgt_q == T_AUD & Audio_Buffer_Full_I)));
    assign accept  = Rx_Valid_I & Rx_Ready_O;
    assign len_dec = len_q - 16'd1;
    assign len_new = {len_hi_q, Rx_Data_I};

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        len_hi_d   = len_hi_q;
        len_d      = len_q;
        vid_wr_d   = 1'b0;
        aud_wr_d   = 1'b0;
        err_d      = 1'b0;
        drop_hit   = 1'b0;
        if (Flush_I) begin
            state_d = S_IDLE;
            len_d   = '0;
        end else if (accept) begin
            if (Rx_SOP_I) begin
                // a SOP always starts a new packet; one with EOP on it is aborted at once
                err_d    = (state_q != S_IDLE) | Rx_EOP_I;
                tgt_d    = (Rx_Data_I == VIDEO_ID) ? T_VID : (Rx_Data_I == AUDIO_ID) ? T_AUD : T_NONE;
                drop_hit = (Rx_Data_I != VIDEO_ID) & (Rx_Data_I != AUDIO_ID);
                state_d  = Rx_EOP_I ? S_IDLE : S_LEN_HI;
            end else begin
                case (state_q)
                    S_IDLE: state_d = S_IDLE;
                    S_LEN_HI: begin
                        len_hi_d = Rx_Data_I;
                        err_d    = Rx_EOP_I;
                        state_d  = Rx_EOP_I ? S_IDLE : S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        len_d   = len_new;
                        err_d   = Rx_EOP_I & (len_new != 16'd0);
                        state_d = Rx_EOP_I ? S_IDLE : (len_new == 16'd0) ? S_WAIT_EOP : S_PAYLOAD;
                    end
                    S_PAYLOAD: begin
                        vid_wr_d = tgt_q == T_VID;
                        aud_wr_d = tgt_q == T_AUD;
                        len_d    = len_dec;
                        err_d    = Rx_EOP_I ? (len_dec != 16'd0) : (len_dec == 16'd0);
                        state_d  = Rx_EOP_I ? S_IDLE : (len_dec == 16'd0) ? S_WAIT_EOP : S_PAYLOAD;
                    end
                    S_WAIT_EOP: state_d = Rx_EOP_I ? S_IDLE : S_WAIT_EOP;
                    default: state_d = S_IDLE;
                endcase
            end
        end
        vid_data_d = vid_wr_d ? Rx_Data_I : vid_data_q;
        aud_data_d = aud_wr_d ? Rx_Data_I : aud_data_q;
        vid_cnt_d  = sat_inc(vid_cnt_q, vid_wr_d);
        aud_cnt_d  = sat_inc(aud_cnt_q, aud_wr_d);
        drop_cnt_d = sat_inc(drop_cnt_q, drop_hit);
        err_cnt_d  = sat_inc(err_cnt_q, err_d);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            tgt_q      <= T_NONE;
            len_hi_q   <= '0;
            len_q      <= '0;
            rdy_q      <= 1'b0;
            vid_wr_q   <= 1'b0;
            vid_data_q <= '0;
            aud_wr_q   <= 1'b0;
            aud_data_q <= '0;
            err_q      <= 1'b0;
            vid_cnt_q  <= '0;
            aud_cnt_q  <= '0;
            drop_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            len_hi_q   <= len_hi_d;
            len_q      <= len_d;
            rdy_q      <= 1'b1;
            vid_wr_q   <= vid_wr_d;
            vid_data_q <= vid_data_d;
            aud_wr_q   <= aud_wr_d;
            aud_data_q <= aud_data_d;
            err_q      <= err_d;
            vid_cnt_q  <= vid_cnt_d;
            aud_cnt_q  <= aud_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign Video_Buffer_Write_O = vid_wr_q;
    assign Video_Data_O         = vid_data_q;
    assign Audio_Buffer_Write_O = aud_wr_q;
    assign Audio_Data_O         = aud_data_q;
    assign Video_Byte_Count_O   = vid_cnt_q;
    assign Audio_Byte_Count_O   = aud_cnt_q;
    assign Drop_Count_O         = drop_cnt_q;
    assign Error_Count_O        = err_cnt_q;
    assign Error_O              = err_q;
endmodule
